// File: rtl/fifo_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_pkg
//  Purpose  : Shared types and constants for the FIFO-fed UART transmitter.
//             Provides the serialiser state encoding and the parity-mode
//             encoding used by the PARITY parameter.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_uart_pkg;

   // Serialiser states. Names carry an S_ prefix so that S_PARITY cannot be
   // confused with the PARITY parameter of the transmitter.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_START  = 3'd2,
      S_DATA   = 3'd3,
      S_PARITY = 3'd4,
      S_STOP   = 3'd5
   } state_t;

   // Parity-mode encoding for the PARITY parameter.
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_baud.sv
`default_nettype none
// ============================================================================
//  Module   : uart_baud_counter
//  Purpose  : Bit-period timer. Counts 0..CLKS_PER_BIT-1 and wraps, and is
//             forced back to 0 by `clear` so every state starts a full period.
//  Ports    : clk       in  system clock
//             rst       in  synchronous active-high reset
//             clear     in  restart the bit period (state entry)
//             bit_tick  out high while count == CLKS_PER_BIT-1 (last cycle)
//             pre_tick  out high while count == CLKS_PER_BIT-2, one cycle
//                           ahead of bit_tick, so the parent can register
//                           outputs that must line up with the last cycle
//  Revision : 1.0  initial release
// ============================================================================
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear || bit_tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign bit_tick = (count == LAST);
   assign pre_tick = (count == PRE);

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_uart_tx
//  Purpose  : Drains a byte FIFO through its read port and serialises each
//             byte as a UART frame: start, LSB-first data, optional parity,
//             1 or 2 stop bits. A byte is popped only from IDLE, so there is
//             at most one pop per frame.
//  Ports    : clk         in  system clock (rising edge)
//             rst         in  synchronous active-high reset
//             tx_en       in  allow fetching the next byte (sampled in IDLE)
//             fifo_empty  in  FIFO empty flag
//             fifo_data   in  FIFO registered read data, valid in LOAD
//             fifo_rd_en  out FIFO read strobe (combinational)
//             tx          out serial line, registered, idle high
//             busy        out registered, high whenever not IDLE
//             frame_done  out registered pulse in the last stop-bit cycle
//  Revision : 1.0  initial release
// ============================================================================
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_en,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);

   if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
      $error("fifo_uart_tx: CLKS_PER_BIT must be 2 or more");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("fifo_uart_tx: PARITY must be 0, 1 or 2");
   end

   localparam int             IDX_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
   localparam logic           HAS_PAR   = (PARITY != PAR_NONE);
   localparam logic           ODD       = (PARITY == PAR_ODD);

   state_t              state, next_state;
   logic [DATA_W-1:0]   shift, shift_n;
   logic [IDX_W-1:0]    idx, idx_n;      // data-bit index, reused for stop bits
   logic                par_bit, par_n;
   logic                tx_d, done_d, clear;
   logic                bit_tick, pre_tick;

   // Leaving IDLE on the same edge as the pop is what limits it to one read.
   assign fifo_rd_en = !rst && (state == S_IDLE) && tx_en && !fifo_empty;
   assign clear      = (next_state != state);

   uart_baud_counter #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .bit_tick (bit_tick),
      .pre_tick (pre_tick)
   );

   always_comb begin
      next_state = state;
      shift_n    = shift;
      idx_n      = idx;
      par_n      = par_bit;
      done_d     = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (fifo_rd_en) next_state = S_LOAD;
         end
         S_LOAD: begin
            shift_n    = fifo_data;
            par_n      = (^fifo_data) ^ ODD;
            next_state = S_START;
         end
         S_START: begin
            if (bit_tick) begin
               next_state = S_DATA;
               idx_n      = '0;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               shift_n = shift >> 1;
               if (idx == LAST_BIT) begin
                  idx_n      = '0;
                  next_state = HAS_PAR ? S_PARITY : S_STOP;
               end else begin
                  idx_n = idx + IDX_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               next_state = S_STOP;
               idx_n      = '0;
            end
         end
         S_STOP: begin
            // Registered one cycle early so the pulse sits in the last cycle.
            if (pre_tick && idx == LAST_STOP) done_d = 1'b1;
            if (bit_tick) begin
               if (idx == LAST_STOP) next_state = S_IDLE;
               else                  idx_n      = idx + IDX_W'(1);
            end
         end
         default: next_state = S_IDLE;
      endcase

      // The line level is registered from the state being entered, so tx
      // always matches the state that is current on the following cycle.
      unique case (next_state)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_n[0];
         S_PARITY: tx_d = par_n;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         shift      <= '0;
         idx        <= '0;
         par_bit    <= 1'b0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= next_state;
         shift      <= shift_n;
         idx        <= idx_n;
         par_bit    <= par_n;
         tx         <= tx_d;
         busy       <= (next_state != S_IDLE);
         frame_done <= done_d;
      end
   end

endmodule
`default_nettype wire
